// File: rtl/ps2_morse_pkg.sv
// ps2_morse_pkg
//    Shared definitions for the PS/2 keyboard to Morse path: Set-2 prefix
//    bytes, the scan-code decoder state encoding, the 6-bit character codes
//    and the scan-code to character lookup. The lookup is also used by
//    morse_code_encoder, so both blocks agree on the character numbering.
package ps2_morse_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BREAK,
      S_EXT,
      S_EXT_BREAK
   } ps2_state_e;

   localparam logic [5:0] CHAR_NONE  = 6'd0;
   localparam logic [5:0] CHAR_A     = 6'd1;
   localparam logic [5:0] CHAR_0     = 6'd27;
   localparam logic [5:0] CHAR_SPACE = 6'd37;

   // Letters map to 1..26, digits to 27..36, space to 37; anything else
   // returns CHAR_NONE, which callers treat as "nothing to queue".
   function automatic logic [5:0] scan_to_char(input logic [7:0] sc);
      logic [5:0] c;
      c = CHAR_NONE;
      case (sc)
         8'h1C: c = CHAR_A + 6'd0;
         8'h32: c = CHAR_A + 6'd1;
         8'h21: c = CHAR_A + 6'd2;
         8'h23: c = CHAR_A + 6'd3;
         8'h24: c = CHAR_A + 6'd4;
         8'h2B: c = CHAR_A + 6'd5;
         8'h34: c = CHAR_A + 6'd6;
         8'h33: c = CHAR_A + 6'd7;
         8'h43: c = CHAR_A + 6'd8;
         8'h3B: c = CHAR_A + 6'd9;
         8'h42: c = CHAR_A + 6'd10;
         8'h4B: c = CHAR_A + 6'd11;
         8'h3A: c = CHAR_A + 6'd12;
         8'h31: c = CHAR_A + 6'd13;
         8'h44: c = CHAR_A + 6'd14;
         8'h4D: c = CHAR_A + 6'd15;
         8'h15: c = CHAR_A + 6'd16;
         8'h2D: c = CHAR_A + 6'd17;
         8'h1B: c = CHAR_A + 6'd18;
         8'h2C: c = CHAR_A + 6'd19;
         8'h3C: c = CHAR_A + 6'd20;
         8'h2A: c = CHAR_A + 6'd21;
         8'h1D: c = CHAR_A + 6'd22;
         8'h22: c = CHAR_A + 6'd23;
         8'h35: c = CHAR_A + 6'd24;
         8'h1A: c = CHAR_A + 6'd25;
         8'h45: c = CHAR_0 + 6'd0;
         8'h16: c = CHAR_0 + 6'd1;
         8'h1E: c = CHAR_0 + 6'd2;
         8'h26: c = CHAR_0 + 6'd3;
         8'h25: c = CHAR_0 + 6'd4;
         8'h2E: c = CHAR_0 + 6'd5;
         8'h36: c = CHAR_0 + 6'd6;
         8'h3D: c = CHAR_0 + 6'd7;
         8'h3E: c = CHAR_0 + 6'd8;
         8'h46: c = CHAR_0 + 6'd9;
         8'h29: c = CHAR_SPACE;
         default: c = CHAR_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo
//    Synchronous show-ahead FIFO: rd_data always shows the head entry, and a
//    pop simply advances past it. A push into a full FIFO is accepted only
//    when a pop happens in the same cycle; otherwise it is refused.
// Ports:
//    clk, rst_n   clock and asynchronous active-low reset
//    push         write push_data this cycle
//    push_data    entry to write
//    pop          consume the head entry (ignored when empty)
//    rd_data      head entry
//    full, empty  occupancy flags
//    level        occupancy, 0..DEPTH
module char_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   lvl_t;

   logic [WIDTH-1:0] mem_q [DEPTH];
   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   lvl_t level_q, level_d;
   logic do_push, do_pop;

   // Pointers are AW bits wide and DEPTH is a power of two, so the natural
   // overflow of the increment is the modulo-DEPTH wrap.
   always_comb begin
      do_pop   = pop && (level_q != '0);
      do_push  = push && ((level_q != lvl_t'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (do_push && !do_pop) level_d = level_q + lvl_t'(1);
      if (do_pop && !do_push) level_d = level_q - lvl_t'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (level_q == lvl_t'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;

endmodule

// File: rtl/ps2_scancode_buffer.sv
// ps2_scancode_buffer
//    Decodes raw PS/2 Set-2 bytes into 6-bit character codes (make codes
//    only; break and extended sequences are swallowed), optionally drops
//    typematic repeats of the held key, and queues the characters for the
//    Morse encoder behind a valid/ready handshake.
// Ports:
//    clk, rst_n                 clock and asynchronous active-low reset
//    ps2_received_data          scan-code byte from ps2_controller
//    ps2_received_data_strb     byte valid this cycle
//    char_code                  head-of-queue character code
//    char_valid                 queue not empty
//    char_ready                 encoder takes char_code this cycle
//    fifo_level                 queue occupancy
//    overflow                   sticky: a character was dropped on a full queue
module ps2_scancode_buffer
   import ps2_morse_pkg::*;
#(
   parameter int DEPTH           = 8,
   parameter bit SUPPRESS_REPEAT = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                ps2_received_data,
   input  logic                      ps2_received_data_strb,
   output logic [5:0]                char_code,
   output logic                      char_valid,
   input  logic                      char_ready,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      overflow
);

   ps2_state_e state_q, state_d;
   logic [7:0] held_q, held_d;
   logic       overflow_q, overflow_d;
   logic       push;
   logic [5:0] push_code;
   logic       fifo_full, fifo_empty, pop_en;

   // Decoder: only strobed bytes move the FSM. The held key remembers the
   // last make so that auto-repeat can be recognised and so that a break
   // only clears it when it names that same key.
   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      push      = 1'b0;
      push_code = scan_to_char(ps2_received_data);
      if (ps2_received_data_strb) begin
         case (state_q)
            S_IDLE: begin
               if (ps2_received_data == SC_BREAK) begin
                  state_d = S_BREAK;
               end else if (ps2_received_data == SC_EXT) begin
                  state_d = S_EXT;
               end else if (!(SUPPRESS_REPEAT && (ps2_received_data == held_q))) begin
                  held_d = ps2_received_data;
                  push   = (push_code != CHAR_NONE);
               end
            end
            S_BREAK: begin
               if (ps2_received_data == held_q) held_d = 8'h00;
               state_d = S_IDLE;
            end
            S_EXT: begin
               state_d = (ps2_received_data == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // A push into a full queue survives only if the head is leaving in the
   // same cycle; otherwise the character is lost and that is latched.
   always_comb begin
      pop_en     = char_valid && char_ready;
      overflow_d = overflow_q || (push && fifo_full && !pop_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         held_q     <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         held_q     <= held_d;
         overflow_q <= overflow_d;
      end
   end

   char_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (6)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_code),
      .pop       (pop_en),
      .rd_data   (char_code),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign char_valid = !fifo_empty;
   assign overflow   = overflow_q;

endmodule

// File: doc/ps2_scancode_buffer.md
Name: ps2_scancode_buffer

Overview:
- Sits between ps2_controller and morse_code_encoder.
- Consumes raw PS/2 Set-2 scan-code bytes and strips prefix and break sequences.
- Suppresses typematic auto-repeat and translates make codes into a compact 6-bit character code.
- Queues characters in a small FIFO and presents them to the encoder with a valid/ready handshake, so fast typing is not lost while a long Morse symbol is playing.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SUPPRESS_REPEAT, 1, 1 = drop repeated make codes while the key is held; 0 = enqueue every make.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_received_data  in  8  scan-code byte from ps2_controller
- ps2_received_data_strb  in  1  one-cycle strobe; byte valid in this cycle
- char_code  out  6  head-of-FIFO character code
- char_valid  out  1  FIFO not empty; char_code is valid
- char_ready  in  1  encoder accepts char_code this cycle
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; a character was dropped because the FIFO was full

Behaviour:
- Reset: while rst_n is low (asynchronous), all state clears. FSM = S_IDLE, held key = 8'h00, pointers = 0, char_valid = 0, char_code = 0, fifo_level = 0, overflow = 0. Reset mid-sequence discards any partial prefix state and all queued characters.
- Character codes:
  - 0 reserved (none).
  - A–Z = 1–26; Set-2 make codes in order: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Digits 0–9 = 27–36; make codes: 45 16 1E 26 25 2E 36 3D 3E 46.
  - Space = 37; make code 29.
  - All other bytes are unmapped.
- FSM (advances only on cycles with ps2_received_data_strb = 1):
  - S_IDLE:
    - byte F0 -> S_BREAK.
    - byte E0 -> S_EXT.
    - Any other byte is a make code:
      - If SUPPRESS_REPEAT = 1 and byte == held, drop it.
      - Otherwise set held = byte; if the byte is mapped, push its character code.
  - S_BREAK: byte is the released key. If byte == held, clear held to 00. Never push. -> S_IDLE.
  - S_EXT: F0 -> S_EXT_BREAK; any other byte is discarded -> S_IDLE. Extended keys never push.
  - S_EXT_BREAK: discard the byte -> S_IDLE.
- FIFO (show-ahead):
  - char_code = mem[rd_ptr]; char_valid = (level != 0).
  - Pop when char_valid && char_ready. char_ready with an empty FIFO is ignored.
  - Push happens on the clock edge where the decode produces a character. char_valid rises the cycle after that edge if the FIFO was empty (latency 1 cycle from strobe).
  - Push and pop in the same cycle: both occur; level is unchanged, including at full.
  - Full, push, no pop: the character is dropped, overflow is set and stays set until reset. Level stays DEPTH.
  - Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- char_code is held stable while char_valid && !char_ready.

Decomposition:
- Shared package/include ps2_morse_pkg:
  - scan-code constants (SC_BREAK = F0, SC_EXT = E0);
  - FSM state encodings;
  - character-code constants (CHAR_NONE, CHAR_A, CHAR_0, CHAR_SPACE);
  - the scan-to-char lookup function, which morse_code_encoder also reuses.
- One sub-module, char_fifo: a parameterised synchronous show-ahead FIFO with push/pop/full/empty/level and async active-low reset. The top-level block holds the FSM, the held-key register and the lookup.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> exactly one character 1; char_valid rises 1 cycle after the 1C strobe; held = 00 at the end.
- SUPPRESS_REPEAT = 1, bytes 1C, 1C, 1C, F0, 1C, 1C -> two entries (1, 1); with SUPPRESS_REPEAT = 0 -> four entries.
- Bytes E0, 75, E0, F0, 75, 16, 0D -> only code 28 queued (extended keys and unmapped 0D dropped).
- char_ready = 0, push 9 distinct mapped makes each followed by its break (DEPTH = 8) -> fifo_level = 8, overflow = 1, and the head is the first character. Then char_ready = 1 for 8 cycles -> codes drain in order and char_valid falls.
- FIFO full, then a push and a pop in the same cycle -> level stays 8, overflow unchanged, the new code appears at the tail.
- rst_n pulsed low between F0 and its key byte, then byte 29 -> code 37 is pushed; the pre-reset break is not applied.
